// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, ALU op/funct codes, stage records.
package mips_pkg;

  localparam int unsigned CtrlRegDst   = 0;
  localparam int unsigned CtrlAluSrc   = 1;
  localparam int unsigned CtrlBeq      = 2;
  localparam int unsigned CtrlBne      = 3;
  localparam int unsigned CtrlMemRead  = 4;
  localparam int unsigned CtrlMemWrite = 5;
  localparam int unsigned CtrlMemtoReg = 6;
  localparam int unsigned CtrlRegWrite = 7;
  localparam int unsigned CtrlAluOpLo  = 8;
  localparam int unsigned CtrlAluOpHi  = 10;
  localparam int unsigned CtrlWidth    = 11;

  typedef enum logic [2:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluFunct = 3'b010,
    AluOri   = 3'b011,
    AluSlt   = 3'b100
  } alu_op_e;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;

  typedef enum logic [1:0] {
    FwdNone  = 2'd0,
    FwdExMem = 2'd1,
    FwdMemWb = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [CtrlWidth-1:0] ctrl;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [5:0]           funct;
    logic [31:0]          rega;
    logic [31:0]          regb;
  } idex_t;

  typedef struct packed {
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  dest;
  } exmem_t;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } memwb_t;

  function automatic logic [31:0] alu_funct(input logic [5:0]  funct,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (funct)
      FunctAdd: r = a + b;
      FunctSub: r = a - b;
      FunctAnd: r = a & b;
      FunctOr:  r = a | b;
      FunctSlt: r = {31'h0, $signed(a) < $signed(b)};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Selects EX operand sources; EX/MEM result takes priority over MEM/WB write-back data.
module forwarding_unit
  import mips_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       exmem_regwrite_i,
  input  logic [4:0] exmem_dest_i,
  input  logic       memwb_regwrite_i,
  input  logic [4:0] memwb_dest_i,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  logic exmem_live;
  logic memwb_live;

  always_comb begin
    exmem_live = exmem_regwrite_i && (exmem_dest_i != 5'd0);
    memwb_live = memwb_regwrite_i && (memwb_dest_i != 5'd0);

    fwd_a_o = FwdNone;
    if (exmem_live && (exmem_dest_i == rs_i)) begin
      fwd_a_o = FwdExMem;
    end else if (memwb_live && (memwb_dest_i == rs_i)) begin
      fwd_a_o = FwdMemWb;
    end

    fwd_b_o = FwdNone;
    if (exmem_live && (exmem_dest_i == rt_i)) begin
      fwd_b_o = FwdExMem;
    end else if (memwb_live && (memwb_dest_i == rt_i)) begin
      fwd_b_o = FwdMemWb;
    end
  end

endmodule

// File: rtl/exmemwb_stages.sv
// EX, MEM and WB back half of a 5-stage MIPS pipeline with on-chip data memory.
// Operand forwarding is built in when MIPS_FORWARDING_EN is defined.
module exmemwb_stages
  import mips_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CtrlWidth-1:0] IDControl,
  input  logic [31:0]          IDInst,
  input  logic [31:0]          IDRegAOut,
  input  logic [31:0]          IDRegBOut,
  output logic                 IDEX_MemRead,
  output logic [4:0]           IDEX_RegisterRt,
  output logic                 MEMWB_RegWrite,
  output logic [4:0]           MEMWB_RegisterRd,
  output logic [31:0]          MEMWB_WriteData
);

  localparam int unsigned AddrW = $clog2(DMEM_WORDS);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic [31:0] op_a, op_rt, op_b, alu_res;
  logic [4:0]  ex_dest;

  logic [31:0]      dmem [DMEM_WORDS] = '{default: 32'h0};
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_rdata;
  logic             mem_we;

  // ID/EX capture
  always_comb begin
    idex_d       = '0;
    idex_d.ctrl  = IDControl;
    idex_d.rs    = IDInst[25:21];
    idex_d.rt    = IDInst[20:16];
    idex_d.rd    = IDInst[15:11];
    idex_d.imm   = {{16{IDInst[15]}}, IDInst[15:0]};
    idex_d.funct = IDInst[5:0];
    idex_d.rega  = IDRegAOut;
    idex_d.regb  = IDRegBOut;
  end

`ifdef MIPS_FORWARDING_EN
  fwd_sel_e fwd_a, fwd_b;
  logic     exmem_regwrite;

  assign exmem_regwrite = exmem_q.regwrite;

  forwarding_unit u_fwd (
    .rs_i             (idex_q.rs),
    .rt_i             (idex_q.rt),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_dest_i     (exmem_q.dest),
    .memwb_regwrite_i (memwb_q.regwrite),
    .memwb_dest_i     (memwb_q.dest),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b)
  );

  always_comb begin
    op_a = idex_q.rega;
    case (fwd_a)
      FwdExMem: op_a = exmem_q.alu;
      FwdMemWb: op_a = memwb_q.wdata;
      default:  op_a = idex_q.rega;
    endcase
    op_rt = idex_q.regb;
    case (fwd_b)
      FwdExMem: op_rt = exmem_q.alu;
      FwdMemWb: op_rt = memwb_q.wdata;
      default:  op_rt = idex_q.regb;
    endcase
  end
`else
  // rs is only consulted for forwarding
  logic unused_rs;
  assign unused_rs = ^idex_q.rs;
  assign op_a      = idex_q.rega;
  assign op_rt     = idex_q.regb;
`endif

  // EX stage
  always_comb begin
    op_b    = idex_q.ctrl[CtrlAluSrc] ? idex_q.imm : op_rt;
    ex_dest = idex_q.ctrl[CtrlRegDst] ? idex_q.rd : idex_q.rt;
    alu_res = '0;
    case (alu_op_e'(idex_q.ctrl[CtrlAluOpHi:CtrlAluOpLo]))
      AluAdd:   alu_res = op_a + op_b;
      AluSub:   alu_res = op_a - op_b;
      AluFunct: alu_res = alu_funct(idex_q.funct, op_a, op_b);
      AluOri:   alu_res = op_a | {16'h0, idex_q.imm[15:0]};
      AluSlt:   alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
      default:  alu_res = '0;
    endcase

    exmem_d          = '0;
    exmem_d.memwrite = idex_q.ctrl[CtrlMemWrite];
    exmem_d.memtoreg = idex_q.ctrl[CtrlMemtoReg];
    exmem_d.regwrite = idex_q.ctrl[CtrlRegWrite];
    exmem_d.alu      = alu_res;
    exmem_d.store    = op_rt;
    exmem_d.dest     = ex_dest;
  end

  // Branch decisions are resolved upstream
  logic unused_branch;
  assign unused_branch = ^idex_q.ctrl[CtrlBne:CtrlBeq];

  // MEM stage: upper address bits and byte offset are ignored, so addresses wrap
  assign mem_addr  = exmem_q.alu[AddrW+1:2];
  assign mem_rdata = dmem[mem_addr];
  assign mem_we    = exmem_q.memwrite && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr] <= exmem_q.store;
    end
  end

  always_comb begin
    memwb_d          = '0;
    memwb_d.regwrite = exmem_q.regwrite && (exmem_q.dest != 5'd0);
    memwb_d.dest     = exmem_q.dest;
    memwb_d.wdata    = exmem_q.memtoreg ? mem_rdata : exmem_q.alu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign IDEX_MemRead     = idex_q.ctrl[CtrlMemRead];
  assign IDEX_RegisterRt  = idex_q.rt;
  assign MEMWB_RegWrite   = memwb_q.regwrite;
  assign MEMWB_RegisterRd = memwb_q.dest;
  assign MEMWB_WriteData  = memwb_q.wdata;

endmodule

// File: tb/tb_exmemwb_stages.sv
// Directed bench for exmemwb_stages; expectations follow MIPS_FORWARDING_EN when defined.
module tb_exmemwb_stages;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] IDControl;
  logic [31:0] IDInst, IDRegAOut, IDRegBOut;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_RegisterRt;
  logic        MEMWB_RegWrite;
  logic [4:0]  MEMWB_RegisterRd;
  logic [31:0] MEMWB_WriteData;

  int checks = 0;
  int errors = 0;

  // Control words: RegDst=1 ALUSrc=2 MemRead=0x10 MemWrite=0x20 MemtoReg=0x40 RegWrite=0x80
  localparam logic [10:0] CtlR   = 11'h281;
  localparam logic [10:0] CtlLw  = 11'h0D2;
  localparam logic [10:0] CtlSw  = 11'h022;
  localparam logic [10:0] CtlAddi = 11'h082;
  localparam logic [10:0] CtlOri = 11'h382;

  exmemwb_stages #(.DMEM_WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .IDControl        (IDControl),
    .IDInst           (IDInst),
    .IDRegAOut        (IDRegAOut),
    .IDRegBOut        (IDRegBOut),
    .IDEX_MemRead     (IDEX_MemRead),
    .IDEX_RegisterRt  (IDEX_RegisterRt),
    .MEMWB_RegWrite   (MEMWB_RegWrite),
    .MEMWB_RegisterRd (MEMWB_RegisterRd),
    .MEMWB_WriteData  (MEMWB_WriteData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one ID-stage slot, then sample 1 time unit after the edge
  task automatic cycle(input logic [10:0] ctl, input logic [31:0] inst,
                       input logic [31:0] a, input logic [31:0] b);
    IDControl = ctl;
    IDInst    = inst;
    IDRegAOut = a;
    IDRegBOut = b;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    cycle(11'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Issue, then two bubbles: instruction is at MEM/WB afterwards
  task automatic run3(input logic [10:0] ctl, input logic [31:0] inst,
                      input logic [31:0] a, input logic [31:0] b);
    cycle(ctl, inst, a, b);
    nop();
    nop();
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] wd);
    check_eq({tag, "_we"}, {31'h0, MEMWB_RegWrite}, {31'h0, we});
    check_eq({tag, "_rd"}, {27'h0, MEMWB_RegisterRd}, {27'h0, rd});
    check_eq({tag, "_wd"}, MEMWB_WriteData, wd);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_idex_mr"}, {31'h0, IDEX_MemRead}, 32'h0);
    check_eq({tag, "_idex_rt"}, {27'h0, IDEX_RegisterRt}, 32'h0);
    check_wb(tag, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    check_all_zero("reset");
    reset = 1'b0;

    // add $3,$1,$2 then sub $5,$3,$1 back to back
    cycle(CtlR, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
    cycle(CtlR, rtype(5'd3, 5'd1, 5'd5, 6'h22), 32'd0, 32'd5);
    nop();
    check_wb("add", 1'b1, 5'd3, 32'd12);
    nop();
`ifdef MIPS_FORWARDING_EN
    check_wb("sub_fwd", 1'b1, 5'd5, 32'd7);
`else
    check_wb("sub_nofwd", 1'b1, 5'd5, 32'hFFFF_FFFB);
`endif
    nop();
    nop();

    // sw $2,8($0) immediately followed by lw $4,8($0)
    cycle(CtlSw, itype(6'h2B, 5'd0, 5'd2, 16'd8), 32'h0, 32'hDEAD_BEEF);
    cycle(CtlLw, itype(6'h23, 5'd0, 5'd4, 16'd8), 32'h0, 32'h0);
    check_eq("idex_memread", {31'h0, IDEX_MemRead}, 32'h1);
    check_eq("idex_rt", {27'h0, IDEX_RegisterRt}, 32'd4);
    nop();
    check_eq("sw_no_we", {31'h0, MEMWB_RegWrite}, 32'h0);
    nop();
    check_wb("lw", 1'b1, 5'd4, 32'hDEAD_BEEF);

    run3(CtlAddi, itype(6'h08, 5'd1, 5'd0, 16'd5), 32'd5, 32'h0);
    check_wb("addi_r0", 1'b0, 5'd0, 32'd10);

    run3(CtlR, rtype(5'd1, 5'd2, 5'd6, 6'h20), 32'h7FFF_FFFF, 32'd1);
    check_wb("add_wrap", 1'b1, 5'd6, 32'h8000_0000);

    run3(CtlR, rtype(5'd1, 5'd2, 5'd7, 6'h2A), 32'hFFFF_FFFF, 32'd1);
    check_wb("slt_neg", 1'b1, 5'd7, 32'd1);

    run3(CtlR, rtype(5'd1, 5'd2, 5'd9, 6'h24), 32'h0000_F0F0, 32'h0000_FF00);
    check_eq("and", MEMWB_WriteData, 32'h0000_F000);

    run3(CtlR, rtype(5'd1, 5'd2, 5'd9, 6'h3F), 32'h1234_5678, 32'h1);
    check_eq("funct_other", MEMWB_WriteData, 32'h0);

    run3(CtlOri, itype(6'h0D, 5'd1, 5'd10, 16'h8001), 32'h0001_0000, 32'h0);
    check_eq("ori_zext", MEMWB_WriteData, 32'h0001_8001);

    // 0x104 aliases word 1 (byte 0x4) in a 64-word memory
    run3(CtlSw, itype(6'h2B, 5'd0, 5'd2, 16'h0104), 32'h0, 32'h1234_5678);
    run3(CtlLw, itype(6'h23, 5'd0, 5'd11, 16'h0004), 32'h0, 32'h0);
    check_wb("alias", 1'b1, 5'd11, 32'h1234_5678);

    // Reset while a store sits in EX/MEM
    run3(CtlSw, itype(6'h2B, 5'd0, 5'd2, 16'd12), 32'h0, 32'h1111_1111);
    cycle(CtlR, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
    cycle(CtlSw, itype(6'h2B, 5'd0, 5'd2, 16'd12), 32'h0, 32'hCAFE_F00D);
    nop();
    check_eq("pre_reset_wd", MEMWB_WriteData, 32'd12);
    reset = 1'b1;
    cycle(CtlLw, itype(6'h23, 5'd0, 5'd9, 16'd12), 32'h0, 32'h0);
    check_all_zero("mid_reset");
    reset = 1'b0;
    run3(CtlLw, itype(6'h23, 5'd0, 5'd8, 16'd12), 32'h0, 32'h0);
    check_wb("mem_kept", 1'b1, 5'd8, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmemwb_stages.md
EXMEMWB_STAGES -- requirements
Module: exmemwb_stages

Interface
REQ-001 Parameter DMEM_WORDS, default 64, SHALL set data-memory depth in 32-bit words (power of two).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 IDControl  input  11  SHALL carry decoded ID-stage control: [0] RegDst, [1] ALUSrc, [2] Beq, [3] Bne, [4] MemRead, [5] MemWrite, [6] MemtoReg, [7] RegWrite, [10:8] ALUOp; all-zero is a bubble.
REQ-005 IDInst  input  32  SHALL be the ID-stage instruction word (rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0]).
REQ-006 IDRegAOut / IDRegBOut  input  32 each  SHALL be the rs/rt register-file read values.
REQ-007 IDEX_MemRead  output  1  SHALL be the ID/EX MemRead bit, for load-use hazard detection.
REQ-008 IDEX_RegisterRt  output  5  SHALL be the ID/EX rt field.
REQ-009 MEMWB_RegWrite  output  1  SHALL be the register-file write enable.
REQ-010 MEMWB_RegisterRd  output  5  SHALL be the write-back destination register.
REQ-011 MEMWB_WriteData  output  32  SHALL be the write-back data.

Function
REQ-012 Three pipeline registers (ID/EX, EX/MEM, MEM/WB) SHALL load every cycle, no stall input; an instruction presented in cycle n SHALL reach the MEM/WB outputs in cycle n+3.
REQ-013 ID/EX SHALL capture IDControl, rs, rt, rd, sign-extended imm, funct, IDRegAOut, IDRegBOut.
REQ-014 Destination SHALL be rd when RegDst=1, else rt.
REQ-015 ALU operand B SHALL be the sign-extended imm when ALUSrc=1, else forwarded rt value.
REQ-016 ALUOp: 000 add, 001 sub, 010 funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, other -> 0), 011 or with zero-extended imm, 100 signed slt, others -> 0.
REQ-017 Arithmetic SHALL wrap modulo 2^32; no overflow detection.
REQ-018 Data memory SHALL be indexed by ALU result bits [log2(DMEM_WORDS)+1:2]; bits [1:0] and upper bits ignored (address wrap).
REQ-019 MEM stage: MemWrite SHALL write forwarded rt value at clock edge; MemRead SHALL read combinationally; a read in the cycle after a write to the same word SHALL return the new data.
REQ-020 WriteData SHALL be memory data when MemtoReg=1, else ALU result.
REQ-021 MEMWB_RegWrite SHALL be 0 whenever destination is $0, regardless of control.
REQ-022 Bubbles (control all-zero) SHALL propagate with no memory or register write.

Reset
REQ-023 Reset SHALL clear all three pipeline registers so every output reads 0 the cycle after reset is sampled.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight instructions; no memory write occurs in a cycle where reset is high.
REQ-025 Data-memory contents SHALL NOT be cleared by reset (zero at elaboration only).

Configuration
REQ-026 Macro MIPS_FORWARDING_EN defined: rs/rt operands SHALL be forwarded from EX/MEM (priority) then MEM/WB when that stage has RegWrite=1, dest!=0, dest matches.
REQ-027 Macro undefined: operands SHALL come only from ID/EX captured values; software inserts nops.

Structure
REQ-028 Shared package mips_pkg SHALL hold control-bit indices, ALUOp codes and funct codes.
REQ-029 Forwarding SHALL be one sub-module, forwarding_unit, instantiated only under MIPS_FORWARDING_EN.

Verification
REQ-030 add $3,$1,$2 with A=5, B=7, ctrl RegDst|RegWrite|ALUOp=010 -> 3 cycles later MEMWB_RegWrite=1, Rd=3, WriteData=12.
REQ-031 sw $2,8($0) B=0xDEADBEEF then lw $4,8($0) -> lw writes back 0xDEADBEEF to rd 4.
REQ-032 Forwarding on: add $3 (=12) then sub $5,$3,$1 (A stale 0, $1=5) -> WriteData=7; off: WriteData=0xFFFFFFFB.
REQ-033 lw in ID/EX -> IDEX_MemRead=1, IDEX_RegisterRt=rt same cycle; addi to $0 -> MEMWB_RegWrite=0.
REQ-034 Reset high one cycle with sw in EX/MEM -> memory word unchanged, all outputs 0 next cycle.
REQ-035 add 0x7FFFFFFF+1 -> 0x80000000; slt -1,1 -> 1; address 0x104 with DMEM_WORDS=64 aliases word 1.
